config_chain_loader: RTL
========================

// Module: config_chain_loader
// PURPOSE
//  Sequences the serial configuration chain formed by daisy-chained tile config
//  shift registers (config_in -> ... -> config_out). Accepts bitstream words
//  from a host over a valid/ready handshake and serialises them LSB-first into
//  the chain. Drives config_enable for exactly CHAIN_LENGTH shift cycles and
//  captures the bits leaving the chain as readback words. Sits between the
//  bitstream source and the first tile of the chain.
// PARAMETERS
//  CHAIN_LENGTH  64  total config bits in the chain (>=1; one IO tile = 4)
//  WORD_WIDTH    8   host word width in bits (>=1)
// PORTS
//  config_clock    in   1           single clock; also clocks the tile chain
//  config_nreset   in   1           asynchronous, active-low reset
//  start           in   1           pulse: begin a load (ignored while busy)
//  abort           in   1           pulse: cancel load, return to IDLE
//  word_data       in   WORD_WIDTH  bitstream word, bit 0 shifted first
//  word_valid      in   1           host has a word
//  word_ready      out  1           loader accepts a word this cycle
//  config_in       out  1           serial bit into the first tile
//  config_enable   out  1           chain shift enable
//  chain_out       in   1           config_out of the last tile
//  readback_word   out  WORD_WIDTH  bits shifted out of the chain, LSB first
//  readback_valid  out  1           1-cycle strobe; no backpressure
//  busy            out  1           load in progress
//  done            out  1           full chain loaded; held until start/abort
// BEHAVIOUR
//  - Reset (async, config_nreset=0): state IDLE; all outputs 0 immediately.
//    Reset mid-load leaves chain contents undefined; host must re-run start.
//  - States: IDLE, LOAD, SHIFT, DONE. bit_cnt = $clog2(CHAIN_LENGTH+1) bits.
//  - IDLE: start=1 -> LOAD next cycle; bit_cnt<=0, done<=0, busy<=1.
//  - LOAD: word_ready=1. Handshake is word_valid&&word_ready in the same cycle;
//    the word is latched, word_bits = min(WORD_WIDTH, CHAIN_LENGTH-bit_cnt),
//    -> SHIFT. word_valid low: stay; config_enable=0 (stall, no bits lost).
//  - SHIFT: word_ready=0, config_enable=1 every cycle, config_in = current LSB
//    of the latched word; chain_out sampled in the same cycle (bit leaving on
//    this edge) into readback bit position k (k = 0..word_bits-1). bit_cnt
//    increments per cycle. After word_bits cycles: readback_valid=1 for one
//    cycle with readback_word (bits >= word_bits are 0); then
//    bit_cnt==CHAIN_LENGTH -> DONE, else -> LOAD.
//  - config_enable high for exactly CHAIN_LENGTH cycles per load, not
//    necessarily contiguous. config_in/config_enable are registered (glitch-
//    free); config_in=0 whenever config_enable=0.
//  - DONE: done=1, busy=0. start -> LOAD (restart, done cleared).
//  - start while busy: ignored. abort in any state: -> IDLE next cycle,
//    config_enable=0, busy=0, done=0, pending readback discarded.
//  - Simultaneous start and abort: abort wins.
//  - Partial last word: upper unused word bits are never shifted.
// STRUCTURE
//  - Shared package kfpga_config_pkg: state enum (IDLE/LOAD/SHIFT/DONE),
//    helper for counter width.
//  - One sub-module config_shift_unit: word serialiser + readback
//    deserialiser + per-word bit counter; top holds FSM and chain bit_cnt.
// TESTING
//  1 CHAIN_LENGTH=4, WORD_WIDTH=8, after reset: start, word 0xA5 -> enable
//    high 4 cycles, config_in 1,0,1,0; readback 0x00; done=1.
//  2 Same, then start, word 0x0F -> config_in 1,1,1,1; readback 0x05
//    (previous nibble returns LSB first).
//  3 CHAIN_LENGTH=20, WORD_WIDTH=8: words 0xFF,0x00,0xFF -> shifts 8,8,4;
//    enable total 20 cycles; 3 readback strobes; done after 3rd.
//  4 word_valid held low 5 cycles in LOAD -> config_enable 0 those cycles,
//    bit_cnt frozen, subsequent bits correct.
//  5 abort on 3rd shift cycle -> IDLE next cycle, enable 0, done 0,
//    no readback strobe; start while busy has no effect.
//  6 config_nreset low mid-SHIFT -> all outputs 0 in the same cycle;
//    fresh start completes normal load.

Source files
------------

// File: rtl/kfpga_config_pkg.sv
// rtl/kfpga_config_pkg.sv - shared state encoding and counter sizing for the config chain loader
package kfpga_config_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Width of a counter that must hold every value 0..max_value inclusive.
  function automatic int cnt_width(input int max_value);
    return (max_value < 2) ? 1 : $clog2(max_value + 1);
  endfunction

endpackage

// File: rtl/config_shift_unit.sv
// rtl/config_shift_unit.sv - serialises one host word into the chain and deserialises the bits leaving it
module config_shift_unit
  import kfpga_config_pkg::*;
#(
  parameter int WORD_WIDTH = 8,
  localparam int KW = cnt_width(WORD_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  load,
  input  logic [WORD_WIDTH-1:0] load_word,
  input  logic [KW-1:0]         load_bits,
  input  logic                  chain_out,
  output logic                  config_in,
  output logic                  config_enable,
  output logic                  last_bit,
  output logic [WORD_WIDTH-1:0] readback_word,
  output logic                  readback_valid
);

  logic [WORD_WIDTH-1:0] shift_q;
  logic [WORD_WIDTH-1:0] rb_q;
  logic [WORD_WIDTH-1:0] rb_next;
  logic [KW-1:0]         bits_q;
  logic [KW-1:0]         k_q;

  assign last_bit = config_enable && (k_q == bits_q - KW'(1));
  // chain_out during an enabled cycle is the bit leaving on the closing edge
  assign rb_next  = rb_q | (WORD_WIDTH'(chain_out) << k_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q        <= '0;
      rb_q           <= '0;
      bits_q         <= '0;
      k_q            <= '0;
      config_in      <= 1'b0;
      config_enable  <= 1'b0;
      readback_word  <= '0;
      readback_valid <= 1'b0;
    end else begin
      readback_valid <= 1'b0;
      if (flush) begin
        config_enable <= 1'b0;
        config_in     <= 1'b0;
        k_q           <= '0;
      end else if (load) begin
        config_enable <= 1'b1;
        config_in     <= load_word[0];
        shift_q       <= load_word >> 1;
        bits_q        <= load_bits;
        k_q           <= '0;
        rb_q          <= '0;
      end else if (config_enable) begin
        rb_q <= rb_next;
        if (last_bit) begin
          config_enable  <= 1'b0;
          config_in      <= 1'b0;
          readback_word  <= rb_next;
          readback_valid <= 1'b1;
        end else begin
          config_in <= shift_q[0];
          shift_q   <= shift_q >> 1;
          k_q       <= k_q + KW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/config_chain_loader.sv
// rtl/config_chain_loader.sv - sequences host words into the tile config chain and returns readback
module config_chain_loader
  import kfpga_config_pkg::*;
#(
  parameter int CHAIN_LENGTH = 64,
  parameter int WORD_WIDTH   = 8
) (
  input  logic                  config_clock,
  input  logic                  config_nreset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [WORD_WIDTH-1:0] word_data,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic                  config_in,
  output logic                  config_enable,
  input  logic                  chain_out,
  output logic [WORD_WIDTH-1:0] readback_word,
  output logic                  readback_valid,
  output logic                  busy,
  output logic                  done
);

  localparam int CW = cnt_width(CHAIN_LENGTH);
  localparam int KW = cnt_width(WORD_WIDTH);

  logic [1:0]    state_q;
  logic [CW-1:0] bit_cnt_q;
  logic [CW-1:0] remaining;
  logic [KW-1:0] word_bits;
  logic          accept;
  logic          last_bit;

  assign word_ready = (state_q == ST_LOAD) && !abort;
  assign accept     = word_ready && word_valid;
  assign remaining  = CW'(CHAIN_LENGTH) - bit_cnt_q;
  // The final word may be partial; its unused upper bits never reach the chain
  assign word_bits  = (int'(remaining) > WORD_WIDTH) ? KW'(WORD_WIDTH) : KW'(remaining);

  always_ff @(posedge config_clock or negedge config_nreset) begin
    if (!config_nreset) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (abort) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q   <= ST_LOAD;
            bit_cnt_q <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (accept) state_q <= ST_SHIFT;
        end
        ST_SHIFT: begin
          bit_cnt_q <= bit_cnt_q + CW'(1);
          if (last_bit) begin
            if (bit_cnt_q + CW'(1) == CW'(CHAIN_LENGTH)) begin
              state_q <= ST_DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              state_q <= ST_LOAD;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  config_shift_unit #(
    .WORD_WIDTH(WORD_WIDTH)
  ) u_shift (
    .clk           (config_clock),
    .rst_n         (config_nreset),
    .flush         (abort),
    .load          (accept),
    .load_word     (word_data),
    .load_bits     (word_bits),
    .chain_out     (chain_out),
    .config_in     (config_in),
    .config_enable (config_enable),
    .last_bit      (last_bit),
    .readback_word (readback_word),
    .readback_valid(readback_valid)
  );

endmodule
